// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU op codes, MIPS opcodes/functs and operand-select encodings.
package cpu_pkg;

    localparam logic [5:0] AluAnd = 6'd36;
    localparam logic [5:0] AluOr  = 6'd37;
    localparam logic [5:0] AluAdd = 6'd32;
    localparam logic [5:0] AluSub = 6'd34;
    localparam logic [5:0] AluSlt = 6'd42;

    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpAddi  = 6'd8;
    localparam logic [5:0] OpSlti  = 6'd10;
    localparam logic [5:0] OpAndi  = 6'd12;
    localparam logic [5:0] OpOri   = 6'd13;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;

    localparam logic [5:0] FnAdd = 6'd32;
    localparam logic [5:0] FnSub = 6'd34;
    localparam logic [5:0] FnAnd = 6'd36;
    localparam logic [5:0] FnOr  = 6'd37;
    localparam logic [5:0] FnSlt = 6'd42;

    typedef enum logic [1:0] {ImmNone, ImmSext, ImmZext} imm_sel_e;
    typedef enum logic {DstRd, DstRt} dst_sel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into ALU op, operand selects and control bits.
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] alu_op,
    output imm_sel_e   imm_sel,
    output dst_sel_e   dst_sel,
    output logic       reg_wen,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       is_branch,
    output logic       illegal
);

    always_comb begin
        alu_op    = 6'd0;
        imm_sel   = ImmNone;
        dst_sel   = DstRt;
        reg_wen   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OpRtype: begin
                dst_sel = DstRd;
                unique case (funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt: begin
                        alu_op  = funct;
                        reg_wen = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpAddi: begin
                alu_op  = AluAdd;
                imm_sel = ImmSext;
                reg_wen = 1'b1;
            end
            OpSlti: begin
                alu_op  = AluSlt;
                imm_sel = ImmSext;
                reg_wen = 1'b1;
            end
            OpAndi: begin
                alu_op  = AluAnd;
                imm_sel = ImmZext;
                reg_wen = 1'b1;
            end
            OpOri: begin
                alu_op  = AluOr;
                imm_sel = ImmZext;
                reg_wen = 1'b1;
            end
            OpLw: begin
                alu_op  = AluAdd;
                imm_sel = ImmSext;
                reg_wen = 1'b1;
                mem_rd  = 1'b1;
            end
            OpSw: begin
                alu_op  = AluAdd;
                imm_sel = ImmSext;
                mem_wr  = 1'b1;
            end
            OpBeq: begin
                alu_op    = AluSub;
                is_branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decode, operand forwarding and stall/flush-controlled registering
// of everything the ALU consumes next cycle.
module alu_issue_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instr,
    input  logic             instr_vld,
    input  logic [XLEN-1:0]  rs_data,
    input  logic [XLEN-1:0]  rt_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             exm_wen,
    input  logic [RADDR-1:0] exm_waddr,
    input  logic [XLEN-1:0]  exm_wdata,
    input  logic             mwb_wen,
    input  logic [RADDR-1:0] mwb_waddr,
    input  logic [XLEN-1:0]  mwb_wdata,
    output logic [XLEN-1:0]  dataA,
    output logic [XLEN-1:0]  dataB,
    output logic [5:0]       Signal,
    output logic [XLEN-1:0]  store_data,
    output logic [RADDR-1:0] dst_addr,
    output logic             reg_wen,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             is_branch,
    output logic             vld,
    output logic             illegal
);

    logic [RADDR-1:0] rs_addr, rt_addr, rd_addr;
    logic [15:0]      imm16;

    assign rs_addr = instr[21+:RADDR];
    assign rt_addr = instr[16+:RADDR];
    assign rd_addr = instr[11+:RADDR];
    assign imm16   = instr[15:0];

    logic [5:0] dec_op;
    imm_sel_e   dec_imm_sel;
    dst_sel_e   dec_dst_sel;
    logic       dec_reg_wen, dec_mem_rd, dec_mem_wr, dec_branch, dec_illegal;

    alu_op_decode u_decode (
        .opcode    (instr[31:26]),
        .funct     (instr[5:0]),
        .alu_op    (dec_op),
        .imm_sel   (dec_imm_sel),
        .dst_sel   (dec_dst_sel),
        .reg_wen   (dec_reg_wen),
        .mem_rd    (dec_mem_rd),
        .mem_wr    (dec_mem_wr),
        .is_branch (dec_branch),
        .illegal   (dec_illegal)
    );

    // Per-source forwarding; $0 is hardwired so never forwarded, EX/MEM is the younger result.
    logic [XLEN-1:0] fwd_rs, fwd_rt;

    always_comb begin
        fwd_rs = rs_data;
        if (rs_addr != '0) begin
            if (exm_wen && exm_waddr == rs_addr)      fwd_rs = exm_wdata;
            else if (mwb_wen && mwb_waddr == rs_addr) fwd_rs = mwb_wdata;
        end
    end

    always_comb begin
        fwd_rt = rt_data;
        if (rt_addr != '0) begin
            if (exm_wen && exm_waddr == rt_addr)      fwd_rt = exm_wdata;
            else if (mwb_wen && mwb_waddr == rt_addr) fwd_rt = mwb_wdata;
        end
    end

    logic [XLEN-1:0] imm_ext, op_b;

    always_comb begin
        unique case (dec_imm_sel)
            ImmSext: imm_ext = {{(XLEN-16){imm16[15]}}, imm16};
            ImmZext: imm_ext = {{(XLEN-16){1'b0}}, imm16};
            default: imm_ext = '0;
        endcase
        op_b = (dec_imm_sel == ImmNone) ? fwd_rt : imm_ext;
    end

    // Bubbles (instr_vld low or illegal) load all-zero fields; only illegal is flagged.
    logic load_ok;
    assign load_ok = instr_vld && !dec_illegal;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dataA      <= '0;
            dataB      <= '0;
            Signal     <= '0;
            store_data <= '0;
            dst_addr   <= '0;
            reg_wen    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            is_branch  <= 1'b0;
            vld        <= 1'b0;
            illegal    <= 1'b0;
        end else if (!stall) begin
            dataA      <= load_ok ? fwd_rs : '0;
            dataB      <= load_ok ? op_b : '0;
            Signal     <= load_ok ? dec_op : '0;
            store_data <= load_ok ? fwd_rt : '0;
            dst_addr   <= !load_ok ? '0 : (dec_dst_sel == DstRd) ? rd_addr : rt_addr;
            reg_wen    <= load_ok && dec_reg_wen;
            mem_rd     <= load_ok && dec_mem_rd;
            mem_wr     <= load_ok && dec_mem_wr;
            is_branch  <= load_ok && dec_branch;
            vld        <= load_ok;
            illegal    <= instr_vld && dec_illegal;
        end
    end

endmodule
